pic_core_n: RTL and testbench

- Synchronous, parametrised successor to the team's 8259A-style PIC.
- Supports NUM_IRQ request lines, a register-mapped programming interface and a clocked two-pulse INTA handshake that returns an 8-bit vector.
- Adds per-instance edge/level mode, auto-EOI, specific/non-specific EOI, rotating priority and spurious-vector handling in a single clock domain.
- Sits between peripheral IRQ sources and the CPU bus interface.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/pic_prio_resolver.sv | 57 +++++
 rtl/pic_core_n.sv | 238 +++++++++++++++++++++++
 tb/tb_pic_core_n.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants and types for the pic_core_n interrupt controller.
package pic_pkg;

    // Register addresses
    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrImr    = 3'd1;
    localparam logic [2:0] AddrVbase  = 3'd2;
    localparam logic [2:0] AddrEoi    = 3'd3;  // write: EOI command, read: IRR
    localparam logic [2:0] AddrIsr    = 3'd4;
    localparam logic [2:0] AddrStatus = 3'd5;

    // CTRL bit positions
    localparam int unsigned CtrlLtim   = 0;
    localparam int unsigned CtrlAeoi   = 1;
    localparam int unsigned CtrlRotate = 2;
    localparam int unsigned CtrlEnable = 3;
    localparam int unsigned CtrlW      = 4;

    // EOI command and STATUS field positions
    localparam int unsigned EoiSpecificBit = 8;
    localparam int unsigned StatusIntBit   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StAck1,
        StAck2
    } pic_state_e;

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating-priority resolver: finds the highest-priority candidate and the
// highest-priority in-service level, with prio_base_i as the top level.
module pic_prio_resolver #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] cand_i,
    input  logic [NUM_IRQ-1:0] isr_i,
    input  logic [IDX_W-1:0]   prio_base_i,
    output logic               winner_valid_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               isr_valid_o,
    output logic [IDX_W-1:0]   isr_top_idx_o
);

    localparam int unsigned SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] idx;
    logic             cand_found;
    logic             isr_found;
    int               cand_off;
    int               isr_off;

    // Walk priority offsets from lowest to highest so the last hit is the top one
    always_comb begin
        cand_found    = 1'b0;
        isr_found     = 1'b0;
        cand_off      = 0;
        isr_off       = 0;
        sum           = '0;
        idx           = '0;
        winner_idx_o  = '0;
        isr_top_idx_o = '0;
        for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
            sum = {1'b0, prio_base_i} + SW'(k);
            if (sum >= SW'(NUM_IRQ)) begin
                sum = sum - SW'(NUM_IRQ);
            end
            idx = sum[IDX_W-1:0];
            if (cand_i[idx]) begin
                cand_found   = 1'b1;
                cand_off     = k;
                winner_idx_o = idx;
            end
            if (isr_i[idx]) begin
                isr_found     = 1'b1;
                isr_off       = k;
                isr_top_idx_o = idx;
            end
        end
        // Fully nested: an in-service level blocks itself and everything below it
        winner_valid_o = cand_found && (!isr_found || (cand_off < isr_off));
        isr_valid_o    = isr_found;
    end

endmodule

// File: rtl/pic_core_n.sv
// 8259A-style programmable interrupt controller with rotating priority,
// edge/level requests, AEOI and a two-pulse INTA vector handshake.
module pic_core_n
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_IRQ),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cs,
    input  logic               wr,
    input  logic               rd,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic               inta,
    output logic               int_o,
    output logic [7:0]         vec_o,
    output logic               vec_valid
);

    localparam logic [NUM_IRQ-1:0] OneHot0 = NUM_IRQ'(1);
    localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(NUM_IRQ - 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LastIdx) ? '0 : i + IDX_W'(1);
    endfunction

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               inta_q;
    logic [CtrlW-1:0]   ctrl_q;
    logic [NUM_IRQ-1:0] imr_q;
    logic [7:0]         vbase_q;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [IDX_W-1:0]   prio_base_q, prio_base_d;
    pic_state_e         state_q;
    logic               int_q;
    logic [7:0]         vec_q;
    logic               vec_valid_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               spurious_q;

    logic [NUM_IRQ-1:0] irq_s;
    logic               reg_wr;
    logic               inta_rise;
    logic               winner_valid;
    logic [IDX_W-1:0]   winner_idx;
    logic               isr_valid;
    logic [IDX_W-1:0]   isr_top_idx;
    logic               ack1_grant;
    logic               ack2_aeoi;
    logic               eoi_wr;
    logic [IDX_W-1:0]   eoi_idx;
    logic               eoi_hit;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic [NUM_IRQ-1:0] unused_wdata;

    assign unused_wdata = NUM_IRQ'(^wdata);

    assign irq_s     = sync_q[SYNC_STAGES-1];
    assign reg_wr    = cs && wr;
    assign inta_rise = inta && !inta_q;

    pic_prio_resolver #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_resolver (
        .cand_i         (irr_q & ~imr_q),
        .isr_i          (isr_q),
        .prio_base_i    (prio_base_q),
        .winner_valid_o (winner_valid),
        .winner_idx_o   (winner_idx),
        .isr_valid_o    (isr_valid),
        .isr_top_idx_o  (isr_top_idx)
    );

    // Input synchronisers plus delayed copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            irq_prev_q <= '0;
            inta_q     <= 1'b0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            irq_prev_q <= irq_s;
            inta_q     <= inta;
        end
    end

    // Programming registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            imr_q   <= '1;
            vbase_q <= '0;
        end else if (reg_wr) begin
            if (addr == AddrCtrl)  ctrl_q  <= wdata[CtrlW-1:0];
            if (addr == AddrImr)   imr_q   <= wdata[NUM_IRQ-1:0];
            if (addr == AddrVbase) vbase_q <= wdata[7:0];
        end
    end

    // Next-state for IRR, ISR and the rotating priority base
    always_comb begin
        ack1_grant = (state_q == StPend) && ctrl_q[CtrlEnable] && inta_rise && winner_valid;
        ack2_aeoi  = (state_q == StAck2) && ctrl_q[CtrlAeoi] && !spurious_q;

        eoi_wr  = reg_wr && (addr == AddrEoi);
        eoi_idx = wdata[EoiSpecificBit] ? wdata[IDX_W-1:0] : isr_top_idx;
        if (wdata[EoiSpecificBit]) begin
            eoi_hit = (32'(wdata[IDX_W-1:0]) < NUM_IRQ) && isr_q[wdata[IDX_W-1:0]];
        end else begin
            eoi_hit = isr_valid;
        end
        eoi_clr = (eoi_wr && eoi_hit) ? (OneHot0 << eoi_idx) : '0;

        // Set after clear so a same-cycle ACK1 set beats an EOI clear
        isr_d = isr_q & ~eoi_clr;
        if (ack2_aeoi) isr_d = isr_d & ~(OneHot0 << gnt_idx_q);
        if (ack1_grant) isr_d = isr_d | (OneHot0 << winner_idx);

        if (ctrl_q[CtrlLtim]) begin
            irr_d = irq_s;
        end else begin
            irr_d = irr_q;
            if (ack1_grant) irr_d = irr_d & ~(OneHot0 << winner_idx);
            irr_d = irr_d | (irq_s & ~irq_prev_q);
        end

        prio_base_d = prio_base_q;
        if (ctrl_q[CtrlRotate]) begin
            if (ack2_aeoi) begin
                prio_base_d = next_idx(gnt_idx_q);
            end else if (eoi_wr && eoi_hit) begin
                prio_base_d = next_idx(eoi_idx);
            end
        end
    end

    // Request/service state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q       <= '0;
            isr_q       <= '0;
            prio_base_q <= '0;
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            prio_base_q <= prio_base_d;
        end
    end

    // INTA handshake FSM with registered int/vector outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            int_q       <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            spurious_q  <= 1'b0;
        end else begin
            vec_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ctrl_q[CtrlEnable] && winner_valid) begin
                        state_q <= StPend;
                        int_q   <= 1'b1;
                    end
                end
                StPend: begin
                    if (!ctrl_q[CtrlEnable]) begin
                        state_q <= StIdle;
                        int_q   <= 1'b0;
                    end else if (inta_rise) begin
                        state_q <= StAck1;
                        int_q   <= 1'b0;
                        // Request withdrawn since int_o rose: hand out the spurious level
                        if (winner_valid) begin
                            gnt_idx_q  <= winner_idx;
                            spurious_q <= 1'b0;
                        end else begin
                            gnt_idx_q  <= LastIdx;
                            spurious_q <= 1'b1;
                        end
                    end
                end
                StAck1: begin
                    if (inta_rise) begin
                        state_q     <= StAck2;
                        vec_q       <= vbase_q + 8'(gnt_idx_q);
                        vec_valid_q <= 1'b1;
                    end
                end
                StAck2: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        if (cs && rd) begin
            case (addr)
                AddrCtrl:   rdata[CtrlW-1:0]   = ctrl_q;
                AddrImr:    rdata[NUM_IRQ-1:0] = imr_q;
                AddrVbase:  rdata[7:0]         = vbase_q;
                AddrEoi:    rdata[NUM_IRQ-1:0] = irr_q;
                AddrIsr:    rdata[NUM_IRQ-1:0] = isr_q;
                AddrStatus: begin
                    rdata[IDX_W-1:0]    = prio_base_q;
                    rdata[StatusIntBit] = int_q;
                end
                default:    rdata = '0;
            endcase
        end
    end

    assign int_o     = int_q;
    assign vec_o     = vec_q;
    assign vec_valid = vec_valid_q;

endmodule

// File: tb/tb_pic_core_n.sv
// Self-checking bench for pic_core_n: directed handshake scenarios followed by
// randomized edge-mode traffic checked against a transaction-level model.
module tb_pic_core_n;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq = '0;
    logic          cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [2:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          inta = 1'b0;
    logic          int_o;
    logic [7:0]    vec_o;
    logic          vec_valid;

    pic_core_n #(
        .NUM_IRQ     (N),
        .IDX_W       (IW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq       (irq),
        .cs        (cs),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .inta      (inta),
        .int_o     (int_o),
        .vec_o     (vec_o),
        .vec_valid (vec_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int vv_count = 0;
    int exp_vv   = 0;

    always @(negedge clk) if (vec_valid === 1'b1) vv_count++;

    // Reference model state
    logic [N-1:0] m_irr, m_isr, m_imr;
    logic [3:0]   m_ctrl;
    logic [7:0]   m_vbase;
    int           m_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int prio_of(input int idx);
        return (idx - m_base + int'(N)) % int'(N);
    endfunction

    function automatic int model_isr_top();
        int best = -1;
        for (int i = 0; i < int'(N); i++)
            if (m_isr[i] && (best < 0 || prio_of(i) < prio_of(best))) best = i;
        return best;
    endfunction

    function automatic int model_winner();
        int top = model_isr_top();
        int best = -1;
        logic [N-1:0] cand = m_irr & ~m_imr;
        for (int i = 0; i < int'(N); i++)
            if (cand[i] && (top < 0 || prio_of(i) < prio_of(top)) &&
                (best < 0 || prio_of(i) < prio_of(best))) best = i;
        return best;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = '1; m_ctrl = '0; m_vbase = '0; m_base = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] mask,
                           input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = rdata;
        cs = 1'b0; rd = 1'b0;
        chk(tag, d & mask, exp);
    endtask

    task automatic set_ctrl(input logic [3:0] c);
        wr_reg(3'd0, 32'(c)); m_ctrl = c;
    endtask

    task automatic set_imr(input logic [N-1:0] m);
        wr_reg(3'd1, 32'(m)); m_imr = m;
    endtask

    task automatic set_vbase(input logic [7:0] v);
        wr_reg(3'd2, 32'(v)); m_vbase = v;
    endtask

    // Edge-mode pulse on a set of lines, then let it settle into IRR
    task automatic raise(input logic [N-1:0] mask);
        @(negedge clk);
        irq = irq | mask;
        tick(2);
        irq = irq & ~mask;
        tick(3);
        m_irr = m_irr | mask;
    endtask

    task automatic wait_int(input string tag);
        int k = 0;
        while (int_o !== 1'b1 && k < 8) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(int_o), 32'd1);
    endtask

    task automatic eoi(input bit specific, input int lvl);
        int t;
        wr_reg(3'd3, specific ? (32'h100 | 32'(lvl)) : 32'h0);
        t = specific ? lvl : model_isr_top();
        if (t >= 0 && m_isr[t]) begin
            m_isr[t] = 1'b0;
            if (m_ctrl[2]) m_base = (t + 1) % int'(N);
        end
    endtask

    // Full two-pulse acknowledge; returns the vector that appeared
    task automatic do_ack(output logic [7:0] v);
        int  w, gnt;
        bit  spur;
        wait_int("int_before_ack");
        w = model_winner();
        @(negedge clk);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        chk("int_low_ack1", 32'(int_o), 32'd0);
        if (w >= 0) begin
            gnt = w; spur = 1'b0;
            m_isr[w] = 1'b1;
            if (!m_ctrl[0]) m_irr[w] = 1'b0;
        end else begin
            gnt = int'(N) - 1; spur = 1'b1;
        end
        tick(1);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        v = vec_o;
        chk("vec_valid_hi", 32'(vec_valid), 32'd1);
        chk("vec_value", 32'(vec_o), 32'(8'(m_vbase + 8'(gnt))));
        exp_vv++;
        tick(1);
        chk("vec_valid_lo", 32'(vec_valid), 32'd0);
        if (m_ctrl[1] && !spur) begin
            m_isr[gnt] = 1'b0;
            if (m_ctrl[2]) m_base = (gnt + 1) % int'(N);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]   v;
        logic [N-1:0] mask;
        int           w, lvl, saved;

        model_reset();
        tick(2);
        rst_n = 1'b1;

        // Reset state
        chk("rst_int", 32'(int_o), 32'd0);
        chk("rst_vec", 32'(vec_o), 32'd0);
        chk("rst_vv", 32'(vec_valid), 32'd0);
        chk_reg("rst_ctrl", 3'd0, '1, 32'h0);
        chk_reg("rst_imr", 3'd1, '1, 32'hFF);
        chk_reg("rst_vbase", 3'd2, '1, 32'h0);
        chk_reg("rst_irr", 3'd3, '1, 32'h0);
        chk_reg("rst_isr", 3'd4, '1, 32'h0);
        chk_reg("rst_status", 3'd5, '1, 32'h0);
        chk_reg("undef_addr", 3'd6, '1, 32'h0);

        // Single edge request with latency bound
        set_ctrl(4'h8);
        set_imr('0);
        set_vbase(8'h40);
        @(negedge clk);
        irq[3] = 1'b1;
        tick(SS + 2);
        chk("int_latency", 32'(int_o), 32'd1);
        irq[3] = 1'b0;
        m_irr[3] = 1'b1;
        do_ack(v);
        chk("vec_irq3", 32'(v), 32'h43);
        chk_reg("isr_irq3", 3'd4, '1, 32'h08);
        chk_reg("irr_irq3", 3'd3, '1, 32'h00);
        eoi(1'b0, 0);
        chk_reg("isr_eoi3", 3'd4, '1, 32'h00);

        // Nesting: irq2 beats irq5, irq5 blocked until EOI
        raise(8'h24);
        do_ack(v);
        chk("vec_irq2", 32'(v), 32'h42);
        tick(4);
        chk("nested_block", 32'(int_o), 32'd0);
        chk_reg("irr_irq5_pend", 3'd3, '1, 32'h20);
        eoi(1'b0, 0);
        do_ack(v);
        chk("vec_irq5", 32'(v), 32'h45);
        eoi(1'b0, 0);
        chk_reg("isr_nest_clr", 3'd4, '1, 32'h00);

        // AEOI + rotate
        set_ctrl(4'hE);
        raise(8'h01);
        do_ack(v);
        chk("vec_rot0", 32'(v), 32'h40);
        chk_reg("isr_aeoi", 3'd4, '1, 32'h00);
        chk_reg("status_base1", 3'd5, '1, 32'h01);
        raise(8'h81);
        do_ack(v);
        chk("vec_rot7", 32'(v), 32'h47);
        do_ack(v);
        chk("vec_rot0b", 32'(v), 32'h40);
        tick(2);
        chk_reg("status_base1b", 3'd5, '1, 32'h01);

        // Level mode: withdrawn request gives spurious vector
        set_ctrl(4'h9);
        @(negedge clk);
        irq[4] = 1'b1;
        m_irr = irq;
        wait_int("level_int");
        irq[4] = 1'b0;
        tick(SS + 2);
        m_irr = '0;
        chk("int_held", 32'(int_o), 32'd1);
        do_ack(v);
        chk("vec_spurious", 32'(v), 32'h47);
        chk_reg("isr_spurious", 3'd4, '1, 32'h00);

        // Masking and specific EOI
        set_imr(8'h10);
        @(negedge clk);
        irq[4] = 1'b1;
        m_irr = irq;
        tick(6);
        chk("masked", 32'(int_o), 32'd0);
        set_imr('0);
        wait_int("unmasked");
        do_ack(v);
        chk("vec_irq4", 32'(v), 32'h44);
        @(negedge clk);
        irq[1] = 1'b1;
        m_irr = irq;
        do_ack(v);
        chk("vec_irq1", 32'(v), 32'h41);
        chk_reg("isr_two", 3'd4, '1, 32'h12);
        irq = '0;
        m_irr = '0;
        tick(4);
        eoi(1'b1, 4);
        chk_reg("isr_spec4", 3'd4, '1, 32'h02);
        eoi(1'b0, 0);
        chk_reg("isr_clr", 3'd4, '1, 32'h00);

        // Reset in the middle of the handshake
        set_ctrl(4'h8);
        tick(2);
        raise(8'h40);
        wait_int("int_irq6");
        @(negedge clk);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_int", 32'(int_o), 32'd0);
        chk("rst_mid_vv", 32'(vec_valid), 32'd0);
        tick(1);
        rst_n = 1'b1;
        model_reset();
        saved = vv_count;
        chk_reg("rst_mid_isr", 3'd4, '1, 32'h00);
        chk_reg("rst_mid_imr", 3'd1, '1, 32'hFF);
        chk_reg("rst_mid_ctrl", 3'd0, '1, 32'h00);
        @(negedge clk);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        tick(3);
        chk("rst_mid_no_vv", 32'(vv_count), 32'(saved));
        chk("rst_mid_vec", 32'(vec_o), 32'h00);

        // Randomized edge-mode traffic against the model
        set_imr('0);
        set_vbase(8'($urandom_range(0, 255)));
        for (int it = 0; it < 40; it++) begin
            if (it % 10 == 0) set_ctrl(4'h8 | 4'($urandom_range(0, 3) << 1));
            mask = N'($urandom_range(0, 255) & $urandom_range(0, 255));
            if (mask != '0) raise(mask);
            else tick(3);
            w = model_winner();
            if (w >= 0) begin
                do_ack(v);
            end else begin
                tick(3);
                chk("rand_no_int", 32'(int_o), 32'd0);
            end
            chk_reg("rand_irr", 3'd3, '1, 32'(m_irr));
            chk_reg("rand_isr", 3'd4, '1, 32'(m_isr));
            if ($urandom_range(0, 2) == 0 && m_isr != '0) begin
                if ($urandom_range(0, 1) == 1) begin
                    lvl = int'($urandom_range(0, N - 1));
                    while (!m_isr[lvl]) lvl = (lvl + 1) % int'(N);
                    eoi(1'b1, lvl);
                end else begin
                    eoi(1'b0, 0);
                end
                chk_reg("rand_isr_eoi", 3'd4, '1, 32'(m_isr));
                chk_reg("rand_base", 3'd5, 32'h7, 32'(m_base));
            end
        end

        tick(4);
        chk("vv_total", 32'(vv_count), 32'(exp_vv));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
